uart_rx: RTL and testbench



---
 rtl/uart_rx_if.sv | 30 +++
 rtl/uart_rx.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial-side and word-side signals of the UART receiver.
//   s_tick       : 16x-baud sampling tick, one clk wide
//   rx           : asynchronous serial line, idle high
//   data_out     : last received word, LSB = first bit received
//   rx_done_tick : one-clk pulse when the word and error flags update
//   frame_err    : stop bit of the last frame sampled low
//   parity_err   : parity mismatch on the last frame
//   busy         : receiver is inside a frame or waiting out a break
// master = receiver, slave = line driver / FIFO side.
interface uart_rx_if #(
   parameter int unsigned DATA_SIZE = 8
);
   logic                 s_tick;
   logic                 rx;
   logic [DATA_SIZE-1:0] data_out;
   logic                 rx_done_tick;
   logic                 frame_err;
   logic                 parity_err;
   logic                 busy;

   modport master (
      input  s_tick, rx,
      output data_out, rx_done_tick, frame_err, parity_err, busy
   );

   modport slave (
      output s_tick, rx,
      input  data_out, rx_done_tick, frame_err, parity_err, busy
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 16x oversampled, LSB-first frames.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : uart_rx_if.master (s_tick, rx in; data_out, rx_done_tick,
//             frame_err, parity_err, busy out)
// Optional feature macro: UART_RX_PARITY_EN adds one parity bit after the
// data bits (sense set by PARITY_ODD); without it parity_err is constant 0.
module uart_rx #(
   parameter int unsigned DATA_SIZE      = 8,
   parameter int unsigned BIT_COUNT_SIZE = $clog2(DATA_SIZE + 1),
   parameter int unsigned PARITY_ODD     = 0
) (
   input logic     clk,
   input logic     reset_n,
   uart_rx_if.master bus
);

   localparam int unsigned SC_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } state_t;

   state_t                    state_q, state_d;
   logic                      busy_q;
   logic                      rx_meta, rx_s;
   logic [SC_W-1:0]           sample_count;
   logic [BIT_COUNT_SIZE-1:0] bit_count;
   logic [DATA_SIZE-1:0]      shift_q;
   logic [DATA_SIZE-1:0]      data_q;
   logic                      frame_err_q;
   logic                      parity_err_q;
   logic                      done_q;

   logic sc_clr_c, sc_inc_c, bc_clr_c, bc_inc_c, shift_en_c, commit_c;
   logic par_latch_c;

   logic mid_bit_c, last_bit_c;
   assign mid_bit_c  = (sample_count == SC_W'(15));
   assign last_bit_c = (bit_count == BIT_COUNT_SIZE'(DATA_SIZE - 1));

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.rx;
         rx_s    <= rx_meta;
      end
   end

   // State register; busy tracks the state that is being entered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
      end else if (bus.s_tick) begin
         state_q <= state_d;
         busy_q  <= (state_d != ST_IDLE);
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (!rx_s) state_d = ST_START;
         ST_START: if (sample_count == SC_W'(7)) state_d = rx_s ? ST_IDLE : ST_DATA;
         ST_DATA: begin
            if (mid_bit_c && last_bit_c) begin
`ifdef UART_RX_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: if (mid_bit_c) state_d = ST_STOP;
`endif
         ST_STOP:  if (mid_bit_c) state_d = rx_s ? ST_IDLE : ST_BREAK;
         ST_BREAK: if (rx_s) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Datapath controls; only acted on when s_tick is high.
   always_comb begin
      sc_clr_c    = 1'b0;
      sc_inc_c    = 1'b0;
      bc_clr_c    = 1'b0;
      bc_inc_c    = 1'b0;
      shift_en_c  = 1'b0;
      commit_c    = 1'b0;
      par_latch_c = 1'b0;
      case (state_q)
         ST_IDLE: if (!rx_s) sc_clr_c = 1'b1;
         ST_START: begin
            if (sample_count == SC_W'(7)) begin
               if (!rx_s) begin
                  sc_clr_c = 1'b1;
                  bc_clr_c = 1'b1;
               end
            end else begin
               sc_inc_c = 1'b1;
            end
         end
         ST_DATA: begin
            if (mid_bit_c) begin
               shift_en_c = 1'b1;
               sc_clr_c   = 1'b1;
               bc_inc_c   = !last_bit_c;
            end else begin
               sc_inc_c = 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (mid_bit_c) begin
               par_latch_c = 1'b1;
               sc_clr_c    = 1'b1;
            end else begin
               sc_inc_c = 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (mid_bit_c) begin
               commit_c = 1'b1;
               sc_clr_c = 1'b1;
            end else begin
               sc_inc_c = 1'b1;
            end
         end
         default: ;
      endcase
   end

`ifdef UART_RX_PARITY_EN
   logic parity_bit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                         parity_bit <= 1'b0;
      else if (bus.s_tick && par_latch_c)   parity_bit <= rx_s;
   end
`else
   // Parity support compiled out; keep the parameter and control referenced.
   logic unused_parity;
   assign unused_parity = ^{1'(PARITY_ODD), par_latch_c};
`endif

   // Counters, shift register and committed frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sample_count <= '0;
         bit_count    <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
      end else if (bus.s_tick) begin
         if (sc_clr_c)      sample_count <= '0;
         else if (sc_inc_c) sample_count <= sample_count + SC_W'(1);
         if (bc_clr_c)      bit_count <= '0;
         else if (bc_inc_c) bit_count <= bit_count + BIT_COUNT_SIZE'(1);
         // Right shift so the first bit received ends up at the LSB.
         if (shift_en_c)    shift_q <= {rx_s, shift_q[DATA_SIZE-1:1]};
         if (commit_c) begin
            data_q      <= shift_q;
            frame_err_q <= ~rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= ((^shift_q) ^ parity_bit) != 1'(PARITY_ODD);
`else
            parity_err_q <= 1'b0;
`endif
         end
      end
   end

   // Done pulse runs every clk so it is exactly one clk wide.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) done_q <= 1'b0;
      else          done_q <= bus.s_tick && commit_c;
   end

   assign bus.data_out     = data_q;
   assign bus.rx_done_tick = done_q;
   assign bus.frame_err    = frame_err_q;
   assign bus.parity_err   = parity_err_q;
   assign bus.busy         = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int unsigned DW       = 8;
   localparam int unsigned BIT_CLKS = 256;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          fe;
      logic          pe;
   } exp_t;

   logic clk;
   logic reset_n;
   int   compared   = 0;
   int   mismatched = 0;
   exp_t exp_q[$];
   logic prev_done = 1'b0;

   uart_rx_if #(.DATA_SIZE(DW)) bus ();

   uart_rx #(.DATA_SIZE(DW), .PARITY_ODD(0)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // s_tick every 16 clk, driven on the falling edge.
   initial begin
      int cnt;
      cnt        = 0;
      bus.s_tick = 1'b0;
      forever begin
         @(negedge clk);
         bus.s_tick = (cnt == 15);
         cnt        = (cnt + 1) % 16;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic drive_bit(input logic b);
      bus.rx = b;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic stop_b, input logic par_b,
                             input logic exp_pe);
      exp_t e;
      e.d  = d;
      e.fe = ~stop_b;
      e.pe = exp_pe;
      exp_q.push_back(e);
      drive_bit(1'b0);
      for (int i = 0; i < int'(DW); i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(par_b);
`else
      if (par_b) ;
`endif
      drive_bit(stop_b);
   endtask

   // Monitor: every done pulse is compared against the next expected frame.
   always @(negedge clk) begin
      exp_t e;
      if (bus.rx_done_tick) begin
         if (prev_done) begin
            compared++;
            mismatched++;
            $display("FAIL pulse_width: rx_done_tick high 2 clk, required 1");
         end else if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_pulse: data_out=0x%0h, required no pulse", bus.data_out);
         end else begin
            e = exp_q.pop_front();
            check("data_out", 32'(bus.data_out), 32'(e.d));
            check("frame_err", 32'(bus.frame_err), 32'(e.fe));
            check("parity_err", 32'(bus.parity_err), 32'(e.pe));
         end
      end
      prev_done = bus.rx_done_tick;
   end

   initial begin
      bus.rx  = 1'b1;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data_out", 32'(bus.data_out), 32'h0);
      check("rst_done", 32'(bus.rx_done_tick), 32'h0);
      check("rst_frame_err", 32'(bus.frame_err), 32'h0);
      check("rst_parity_err", 32'(bus.parity_err), 32'h0);
      check("rst_busy", 32'(bus.busy), 32'h0);
      reset_n = 1'b1;
      drive_bit(1'b1);

      // Basic frame.
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      check("busy_after_a5", 32'(bus.busy), 32'h0);

      // Back-to-back, no idle gap.
      send_frame(8'h00, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      drive_bit(1'b1);

      // 5-tick start glitch must be rejected.
      bus.rx = 1'b0;
      repeat (5 * 16) @(negedge clk);
      drive_bit(1'b1);
      drive_bit(1'b1);
      check("glitch_busy", 32'(bus.busy), 32'h0);
      check("glitch_data_out", 32'(bus.data_out), 32'hFF);

      // Framing error followed by a long break.
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      bus.rx = 1'b0;
      repeat (40 * BIT_CLKS) @(negedge clk);
      check("break_busy", 32'(bus.busy), 32'h1);
      check("break_frame_err", 32'(bus.frame_err), 32'h1);
      drive_bit(1'b1);
      check("break_release_busy", 32'(bus.busy), 32'h0);
      send_frame(8'h12, 1'b1, 1'b0, 1'b0);
      check("after_break_frame_err", 32'(bus.frame_err), 32'h0);
      drive_bit(1'b1);

      // Reset in the middle of the data bits of 0x77.
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b1);
      reset_n = 1'b0;
      bus.rx  = 1'b1;
      #1;
      check("midrst_data_out", 32'(bus.data_out), 32'h0);
      check("midrst_busy", 32'(bus.busy), 32'h0);
      check("midrst_frame_err", 32'(bus.frame_err), 32'h0);
      check("midrst_done", 32'(bus.rx_done_tick), 32'h0);
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) drive_bit(1'b1);
      check("midrst_no_pulse_data", 32'(bus.data_out), 32'h0);
      send_frame(8'h81, 1'b1, 1'b0, 1'b0);
      drive_bit(1'b1);

`ifdef UART_RX_PARITY_EN
      send_frame(8'h03, 1'b1, 1'b0, 1'b0);
      send_frame(8'h03, 1'b1, 1'b1, 1'b1);
      drive_bit(1'b1);
`endif

      repeat (64) @(negedge clk);
      check("all_frames_received", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
